// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background SECDED scrubber driving a shared codec and a codeword SRAM port.
// Optional sticky uncorrectable-error interrupt is built when SCRUB_IRQ_EN is defined.
module ecc_scrub_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int INTERVAL   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en,
  input  logic                  scrub_pause,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  cod_decode_en,
  output logic                  cod_encode_en,
  output logic [31:0]           cod_codeword,
  output logic [DATA_WIDTH-1:0] cod_data,
  input  logic [DATA_WIDTH-1:0] cod_data_out,
  input  logic [31:0]           cod_codeword_out,
  input  logic                  cod_err_det,
  input  logic                  cod_err_corr,
  output logic                  busy,
  output logic                  pass_done,
  output logic [15:0]           corr_cnt,
  output logic [15:0]           uncorr_cnt,
  output logic [ADDR_WIDTH-1:0] last_uncorr_addr,
  output logic                  irq
);
  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_RD, S_DEC, S_CHK, S_ENC, S_WBW, S_WB, S_NXT
  } state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           cw_q, cw_d, wd_q, wd_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [15:0]           corr_q, corr_d, uncorr_q, uncorr_d;
  logic                  at_end, uncorr_hit;
  assign at_end     = addr_q == ADDR_WIDTH'(DEPTH - 1);
  assign uncorr_hit = state_q == S_CHK && cod_err_det && !cod_err_corr;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    cw_d     = cw_q;
    dat_d    = dat_q;
    wd_d     = wd_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: if (scrub_en) begin
        state_d = S_WAIT;
        cnt_d   = CW'(INTERVAL - 1);
      end
      S_WAIT: if (!scrub_en) state_d = S_IDLE;
        else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (!scrub_pause) state_d = S_RD;
      S_RD: if (mem_ack) begin
        cw_d    = mem_rdata;
        state_d = S_DEC;
      end
      S_DEC: state_d = S_CHK;
      S_CHK: begin
        dat_d   = cod_data_out;
        state_d = (cod_err_det && cod_err_corr) ? S_ENC : S_NXT;
        if (cod_err_det && cod_err_corr) corr_d = corr_q + 16'(corr_q != 16'hFFFF);
        if (uncorr_hit) begin
          uncorr_d = uncorr_q + 16'(uncorr_q != 16'hFFFF);
          last_d   = addr_q;
        end
      end
      S_ENC: state_d = S_WBW;
      S_WBW: begin
        wd_d    = cod_codeword_out;
        state_d = S_WB;
      end
      S_WB: if (mem_ack) state_d = S_NXT;
      S_NXT: begin
        addr_d  = at_end ? '0 : addr_q + ADDR_WIDTH'(1);
        state_d = scrub_en ? S_WAIT : S_IDLE;
        cnt_d   = CW'(INTERVAL - 1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      cw_q     <= '0;
      dat_q    <= '0;
      wd_q     <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      cw_q     <= cw_d;
      dat_q    <= dat_d;
      wd_q     <= wd_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      last_q   <= last_d;
    end
  end
  // Datapath outputs are gated by state so idle buses read as zero.
  assign mem_req          = state_q == S_RD || state_q == S_WB;
  assign mem_we           = state_q == S_WB;
  assign mem_addr         = mem_req ? addr_q : '0;
  assign mem_wdata        = mem_we ? wd_q : '0;
  assign cod_decode_en    = state_q == S_DEC;
  assign cod_encode_en    = state_q == S_ENC;
  assign cod_codeword     = (state_q == S_DEC || state_q == S_CHK) ? cw_q : '0;
  assign cod_data         = cod_encode_en ? dat_q : '0;
  assign busy             = !(state_q == S_IDLE || state_q == S_WAIT);
  assign pass_done        = state_q == S_NXT && at_end;
  assign corr_cnt         = corr_q;
  assign uncorr_cnt       = uncorr_q;
  assign last_uncorr_addr = last_q;
`ifdef SCRUB_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = (state_q == S_IDLE && !scrub_en) ? 1'b0 : (irq_q || uncorr_hit);
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule
